// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared scan direction, scan order and writer FSM types
package pixel_pkg;

  typedef enum logic {FWD = 1'b0, REV = 1'b1} scan_dir_t;

  typedef enum logic {SNAKE = 1'b0, RASTER = 1'b1} scan_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } writer_state_t;

endpackage

// File: rtl/snake_addr_gen.sv
// rtl/snake_addr_gen.sv - scan position, direction and row base tracker for the pixel writer
module snake_addr_gen
  import pixel_pkg::*;
#(
  parameter int X_MAX = 5,
  parameter int Y_MAX = 5,
  parameter int MODE  = 0,
  localparam int XW = $clog2(X_MAX),
  localparam int YW = $clog2(Y_MAX),
  localparam int AW = $clog2(X_MAX * Y_MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          adv,
  input  logic [XW-1:0] max_x_in,
  input  logic [YW-1:0] max_y_in,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [AW-1:0] row_base,
  output logic          last
);

  localparam scan_mode_t MODE_E = scan_mode_t'(1'(MODE));

  logic [XW-1:0] x_q, x_d, max_x_q, max_x_d;
  logic [YW-1:0] y_q, y_d, max_y_q, max_y_d;
  logic [AW-1:0] row_base_q, row_base_d;
  scan_dir_t     dir_q, dir_d;

  logic x_at_end, x_at_start, row_end;

  assign x_at_end   = (x_q == max_x_q - XW'(1));
  assign x_at_start = (x_q == '0);

  // Snake frames end on the side the final row travels towards, which depends on row-count parity.
  always_comb begin
    row_end = x_at_end;
    if (MODE_E == SNAKE && !max_y_q[0]) row_end = x_at_start;
  end

  assign last = (y_q == max_y_q - YW'(1)) && row_end;

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    row_base_d = row_base_q;
    max_x_d    = max_x_q;
    max_y_d    = max_y_q;
    if (init) begin
      max_x_d    = max_x_in;
      max_y_d    = max_y_in;
      x_d        = '0;
      y_d        = '0;
      dir_d      = FWD;
      row_base_d = '0;
    end else if (adv && last) begin
      x_d        = '0;
      y_d        = '0;
      dir_d      = FWD;
      row_base_d = '0;
    end else if (adv) begin
      if (MODE_E == RASTER) begin
        if (x_at_end) begin
          x_d        = '0;
          y_d        = y_q + YW'(1);
          row_base_d = row_base_q + AW'(max_x_q);
        end else begin
          x_d = x_q + XW'(1);
        end
      end else if (dir_q == FWD) begin
        if (x_at_end) begin
          y_d        = y_q + YW'(1);
          dir_d      = REV;
          row_base_d = row_base_q + AW'(max_x_q);
        end else begin
          x_d = x_q + XW'(1);
        end
      end else begin
        if (x_at_start) begin
          y_d        = y_q + YW'(1);
          dir_d      = FWD;
          row_base_d = row_base_q + AW'(max_x_q);
        end else begin
          x_d = x_q - XW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      dir_q      <= FWD;
      row_base_q <= '0;
      max_x_q    <= '0;
      max_y_q    <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      row_base_q <= row_base_d;
      max_x_q    <= max_x_d;
      max_y_q    <= max_y_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign row_base = row_base_q;

endmodule

// File: rtl/snake_pixel_writer.sv
// rtl/snake_pixel_writer.sv - scan-ordered pixel stream to raster SRAM writes; optional SNAKE_WRITER_BOUNDS_CHECK_EN
module snake_pixel_writer
  import pixel_pkg::*;
#(
  parameter int X_MAX  = 5,
  parameter int Y_MAX  = 5,
  parameter int DATA_W = 8,
  parameter int MODE   = 0,
  localparam int XW = $clog2(X_MAX),
  localparam int YW = $clog2(Y_MAX),
  localparam int AW = $clog2(X_MAX * Y_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [XW-1:0]     max_x,
  input  logic [YW-1:0]     max_y,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [XW-1:0]     curr_x,
  output logic [YW-1:0]     curr_y,
  output logic              busy,
  output logic              frame_done,
  output logic              addr_err
);

  writer_state_t     state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic          start_go, zero_size, accept, beat_ok, gen_last;
  logic [XW-1:0] gen_x;
  logic [YW-1:0] gen_y;
  logic [AW-1:0] gen_row_base, beat_addr;

  assign start_go  = (state_q == ST_IDLE) && start;
  assign zero_size = (max_x == '0) || (max_y == '0);
  assign in_ready  = (state_q == ST_RUN) && (!wr_en_q || wr_ready);
  assign accept    = in_valid && in_ready;
  assign beat_addr = gen_row_base + AW'(gen_x);

  snake_addr_gen #(
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX),
    .MODE  (MODE)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .init     (start_go),
    .adv      (accept),
    .max_x_in (max_x),
    .max_y_in (max_y),
    .x        (gen_x),
    .y        (gen_y),
    .row_base (gen_row_base),
    .last     (gen_last)
  );

`ifdef SNAKE_WRITER_BOUNDS_CHECK_EN
  localparam int CW = AW + XW + YW;
  logic [CW-1:0] area_q, area_d;
  logic          addr_err_q, addr_err_d;
  logic          oob;

  assign oob     = (CW'(gen_row_base) + CW'(gen_x)) >= area_q;
  assign beat_ok = !oob;

  always_comb begin
    area_d     = area_q;
    addr_err_d = addr_err_q;
    if (start_go) begin
      area_d     = CW'(max_x) * CW'(max_y);
      addr_err_d = 1'b0;
    end else if (accept && oob) begin
      addr_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      area_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      area_q     <= area_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_err = addr_err_q;
`else
  assign beat_ok  = 1'b1;
  assign addr_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_en_q && wr_ready) wr_en_d = 1'b0;
    if (accept) begin
      wr_en_d   = beat_ok;
      wr_addr_d = beat_addr;
      wr_data_d = in_data;
    end
    case (state_q)
      ST_IDLE:  if (start) state_d = zero_size ? ST_DONE : ST_RUN;
      ST_RUN:   if (accept && gen_last) state_d = ST_DRAIN;
      // Leave DRAIN as the final write completes so frame_done lands on the following cycle.
      ST_DRAIN: if (!wr_en_q || wr_ready) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign curr_x     = gen_x;
  assign curr_y     = gen_y;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign frame_done = (state_q == ST_DONE);

endmodule
